// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid-register stage.
package pipe_pkg;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 32;

    // 2'b11 is not a member; the stage recovers from it to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_t;

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit event counter that sticks at all-ones; clr is synchronous and wins over inc.
module sat_cnt32 (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and flush.
// Define PIPE_SKID_PERF_EN to add saturating stall_cnt / bubble_cnt outputs.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             acc_in;
    logic             acc_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush overrides the handshake, so a coincident valid/ready pair is not a transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state_d = ST_HALF;
                        main_d  = in_data;
                    end
                end
                ST_HALF: begin
                    case ({acc_in, acc_out})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = ST_FULL;
                            skid_d  = in_data;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                            main_d  = NOP_VALUE;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    if (acc_out) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
        out_data  = main_q;
        acc_in    = in_valid && in_ready;
        acc_out   = out_valid && out_ready;
    end

`ifdef PIPE_SKID_PERF_EN
    sat_cnt32 u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

    sat_cnt32 u_bubble_cnt (
        .clk (clk),
        .clr (rst),
        .inc (!out_valid),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboard-checked bench for pipe_skid_reg (WIDTH=32, NOP_VALUE=0).
module tb_pipe_skid_reg;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH     (W),
        .NOP_VALUE ({W{1'b0}})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_emit got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = W'(i);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== W'(i) || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", i, out_valid, out_data, in_ready, W'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            tests_failed++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_half got v=%b d=%h r=%b exp v=1 d=a r=1", out_valid, out_data, in_ready);
        end
        in_data = 32'hB;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_full got v=%b d=%h r=%b exp v=1 d=a r=0", out_valid, out_data, in_ready);
        end
        in_valid = 1'b0; in_data = 32'hEE;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=a r=0", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_pop_a got v=%b d=%h r=%b exp v=1 d=b r=1", out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            tests_failed++; $display("FAIL bp_pop_b got v=%b d=%h exp v=0 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_full got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_full_after got v=%b exp 0", out_valid); end
        // flush from HALF with an acceptable input: that input must also be dropped
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        tick();
        flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_half got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_half_after got v=%b exp 0", out_valid); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h21; tick();
        in_data = 32'h22; tick();
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_full got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_no_comb_path();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h31; tick();
        in_valid = 1'b0;
        out_ready = 1'b1; #2;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL comb_half got r=%b exp 1", in_ready); end
        out_ready = 1'b0; #1;
        in_valid = 1'b1; in_data = 32'h32; tick();
        in_valid = 1'b0;
        out_ready = 1'b1; #2;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL comb_full got r=%b exp 0", in_ready); end
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        int           errs = 0;
        bit           exp_rdy;
        bit           exp_vld;
        logic [W-1:0] exp_dat;
        for (int n = 0; n < 3000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = in_valid ? W'($urandom) : 'x;
            out_ready = 1'($urandom_range(0, 1));
            exp_rdy = (q.size() < 2);
            exp_vld = (q.size() > 0);
            exp_dat = exp_vld ? q[0] : '0;
            tests_run++;
            if (in_ready !== exp_rdy || out_valid !== exp_vld || out_data !== exp_dat) begin
                tests_failed++;
                errs++;
                if (errs <= 8)
                    $display("FAIL random_cyc%0d got v=%b d=%h r=%b exp v=%b d=%h r=%b",
                             n, out_valid, out_data, in_ready, exp_vld, exp_dat, exp_rdy);
            end
            if (exp_vld && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL random_drain got v=%b exp 0", out_valid); end
    endtask

`ifdef PIPE_SKID_PERF_EN
    task automatic test_perf();
        logic [31:0] bub_before;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h55;
        tick();                         // empty cycle: bubble=1
        in_valid = 1'b0;
        repeat (5) tick();              // stalled: stall=5
        out_ready = 1'b1;
        tick();                         // transfer cycle: neither counts
        repeat (3) tick();              // empty: bubble=4
        tests_run++;
        if (stall_cnt !== 32'd5) begin tests_failed++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
        tests_run++;
        if (bubble_cnt !== 32'd4) begin tests_failed++; $display("FAIL perf_bubble got %0d exp 4", bubble_cnt); end
        bub_before = bubble_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        tests_run++;
        if (stall_cnt !== 32'd5 || bubble_cnt !== bub_before + 32'd1) begin
            tests_failed++; $display("FAIL perf_flush got s=%0d b=%0d exp s=5 b=%0d", stall_cnt, bubble_cnt, bub_before + 32'd1);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL perf_rst got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_full();
        test_no_comb_path();
        test_random();
`ifdef PIPE_SKID_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
